// File: rtl/popcount_stream_if.sv
// Streaming interface for popcount_stream: input word handshake plus
// result handshake. The slave modport is the counter's view.
interface popcount_stream_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_cnt;

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_cnt
  );

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_cnt
  );
endinterface

// File: rtl/popcount_stream.sv
// Streaming ones/zeros counter: one WIDTH-bit word per cycle in, a
// registered count out one cycle later, plus a saturating running total
// and a wrapping word counter updated at input acceptance.
module popcount_stream #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  popcount_stream_if.slave   s,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_sat,
  output logic [ACC_W-1:0]   word_cnt
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             vld_q;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             sat_hit;

  // Output stage frees up when empty or drained this cycle.
  assign s.in_ready  = !vld_q || s.out_ready;
  assign s.out_valid = vld_q;
  assign s.out_cnt   = cnt_q;
  assign accept      = s.in_valid && s.in_ready;

  // Count ones of the (optionally inverted) word.
  always_comb begin
    word  = s.mode ? ~s.in_data : s.in_data;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) cnt_d = cnt_d + CNT_W'(word[i]);
  end

  // One extra bit on the sum lets overflow be seen before clamping.
  always_comb begin
    sum     = {1'b0, acc} + (ACC_W+1)'(cnt_d);
    sat_hit = (sum >= ACC_MAX);
  end

  // Result register, running total and word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      acc      <= '0;
      acc_sat  <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (accept) begin
        vld_q <= 1'b1;
        cnt_q <= cnt_d;
      end else if (s.out_ready) begin
        vld_q <= 1'b0;
      end

      // clr restarts tracking; a word accepted alongside it is the first one counted.
      if (clr) begin
        acc      <= accept ? ACC_W'(cnt_d) : '0;
        acc_sat  <= accept && (ACC_W'(cnt_d) == {ACC_W{1'b1}});
        word_cnt <= accept ? ACC_W'(1) : '0;
      end else if (accept) begin
        acc      <= sat_hit ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        acc_sat  <= acc_sat | sat_hit;
        word_cnt <= word_cnt + ACC_W'(1);
      end
    end
  end
endmodule

// File: doc/popcount_stream.md
Name: popcount_stream

Overview:
- Parametrised sequential successor to the 3-input ones-counter (y1,y0 = number of 1s in a,b,c).
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and returns a registered per-word count of ones (or zeros), one cycle later.
- Also keeps a saturating running total and a word counter for result tracking.
- Sits between a stimulus or data source and any downstream consumer or scoreboard.

Parameters:
- WIDTH, 8, input word width in bits (>= 1).
- ACC_W, 16, width of the running total and of the word counter (>= CNT_W).
- CNT_W, $clog2(WIDTH+1), derived localparam: width of the per-word count (WIDTH=3 gives 2, matching y1,y0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- clr  input  1  synchronous clear of acc, acc_sat and word_cnt only.
- mode  input  1  0 = count ones, 1 = count zeros; sampled on input handshake.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to count.
- out_valid  output  1  out_cnt holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- out_cnt  output  CNT_W  count for the last accepted word.
- acc  output  ACC_W  saturating sum of all out_cnt values accepted since reset/clr.
- acc_sat  output  1  sticky flag: acc has saturated.
- word_cnt  output  ACC_W  number of words accepted, wraps modulo 2^ACC_W.

Behaviour:
- Reset (rst_n=0 at a posedge): all of the following are 0 on the next cycle: out_valid, out_cnt, acc, acc_sat, word_cnt. in_ready is 1 after reset.
  - Mid-operation reset drops any pending result; no handshake completes in that cycle.
- in_ready = !out_valid || out_ready (combinational).
  - Full-throughput pipeline: one word per cycle under continuous out_ready.
- Input accept (in_valid && in_ready at a posedge), on that edge:
  - out_cnt <= popcount(mode ? ~in_data : in_data).
  - out_valid <= 1.
  - word_cnt <= word_cnt + 1, wrapping.
  - acc <= min(acc + count, 2^ACC_W-1).
  - acc_sat <= 1 if the sum would exceed 2^ACC_W-1 or equals it exactly.
- Latency: result is visible the cycle after acceptance.
- Output hold:
  - If out_valid && !out_ready, out_cnt and out_valid hold stable and in_ready=0.
  - If out_ready && !accept, out_valid <= 0 and out_cnt holds its last value.
- Simultaneous out handshake and in accept: new result replaces the old; out_valid stays 1.
- acc/word_cnt are updated at input acceptance, not at output consumption.
- clr:
  - clr=1 with no accept: acc, acc_sat and word_cnt <= 0.
  - clr=1 with an accept in the same cycle: acc <= count of that word, word_cnt <= 1, and acc_sat <= (count == 2^ACC_W-1).
  - clr does not affect out_valid or out_cnt.
  - rst_n takes priority over clr.
- Boundaries:
  - All-zero word gives 0 in mode 0 and WIDTH in mode 1.
  - All-ones word gives WIDTH in mode 0.
  - out_cnt never exceeds WIDTH.
- in_data, mode and in_valid changes while in_ready=0 are ignored.
- No combinational path from in_data to any output.
- The inputs a,b,c of the original ones-counter map to in_data[2:0] with WIDTH=3; out_cnt[1] corresponds to y1 and out_cnt[0] to y0.

Test Plan:
- WIDTH=3, mode=0, out_ready=1; stream all 8 words 000..111 on consecutive cycles:
  - out_cnt sequence = 0,1,1,2,1,2,2,3, each appearing one cycle after its word.
  - acc=12, word_cnt=8.
- WIDTH=8, mode=1, one word 8'h0F -> out_cnt=4.
- WIDTH=8, mode=1, one word 8'h00 -> out_cnt=8.
- Backpressure: accept 8'hFF, hold out_ready=0 for 3 cycles while in_valid=1 with 8'h01:
  - in_ready=0 and out_cnt=8 stable during the stall.
  - Release out_ready: 8'h01 is accepted on the release cycle and out_cnt=1 on the next cycle.
  - word_cnt=2.
- Saturation: ACC_W=4, WIDTH=8, feed 8'hFF twice:
  - acc=8, then acc=15 with acc_sat=1.
  - A further 8'h01 leaves acc=15, acc_sat=1.
  - clr alone -> acc=0, acc_sat=0, word_cnt=0.
- Reset mid-stream: assert rst_n=0 with out_valid=1 and in_valid=1:
  - Next cycle: out_valid=0, acc=0, word_cnt=0, in_ready=1, and the offered word is not counted.
- clr together with accept of 8'h07 (mode 0) -> acc=3, word_cnt=1 next cycle.
